pe_sequencer: RTL and testbench
===============================

# pe_sequencer

Phase sequencer that drives the 2-bit select of the PE-array datapath mux (load / shift / write-back) and handles the handshakes on both sides of the array. On `start` it runs a fixed-length job: accepts `LOAD_LEN` input words from the loader, enables `SHIFT_LEN` shift/compute cycles, then presents `WB_LEN` write-back words downstream, and finally pulses `done`. It sits beside each PE column's data mux; the mux is purely combinational, so the sequencer is the only sequential owner of the select code.

## Interface
Parameters:
- `LOAD_LEN`, default 8: input beats per job. Legal range is 1..255.
- `SHIFT_LEN`, default 16: shift/compute cycles per job. Legal range is 1..255.
- `WB_LEN`, default 4: write-back beats per job. Legal range is 1..255.
- `CNT_W`, default 8: phase counter width. Must be at least the width needed to hold the largest length.

Ports (one clock; reset is synchronous and active-low):
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: job request. Sampled only in IDLE.
- `abort`, input, 1: synchronous abort.
- `ld_valid`, input, 1: the loader has a word.
- `ld_ready`, output, 1: the sequencer accepts a word (asserted in LOAD).
- `pe_en`, output, 1: shift enable to the PE registers (asserted in SHIFT).
- `wb_valid`, output, 1: a write-back word is presented (asserted in WB).
- `wb_ready`, input, 1: the downstream consumer takes the word.
- `sel`, output, 2: mux select. The codes are: 00 = load, 01 = shift, 10 = write-back, 11 = idle. Code 11 makes the mux output zero.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse at job completion.
- `beat_cnt`, output, `CNT_W`: beats or cycles completed in the current phase.

## Operation
- There are five states: IDLE, LOAD, SHIFT, WB, DONE.
- The machine is Moore. All outputs are registered and decoded from state and counter only. No input-to-output combinational path exists.
- IDLE: `sel`=11, all enables are 0.
  - `start`=1 → LOAD, and the counter is cleared.
- LOAD: `sel`=00, `ld_ready`=1.
  - A beat is counted when `ld_valid`&`ld_ready`.
  - On the beat that makes the count `LOAD_LEN` → SHIFT, and the counter is cleared.
  - When `ld_valid`=0 the state and counter hold. This is a stall, not an error.
- SHIFT: `sel`=01, `pe_en`=1. The counter increments every cycle unconditionally.
  - After exactly `SHIFT_LEN` cycles → WB, and the counter is cleared.
- WB: `sel`=10, `wb_valid`=1.
  - A beat is counted when `wb_valid`&`wb_ready`.
  - On the `WB_LEN`-th beat → DONE.
  - When `wb_ready`=0, `wb_valid` stays high and `sel` stays 10. Backpressure is held indefinitely.
- DONE: `sel`=11, `done`=1 for exactly one cycle, then → IDLE.
  - `start` in DONE is ignored, so back-to-back jobs have a minimum 1-cycle IDLE gap.
- `start` outside IDLE is ignored. It is not queued.
- `abort` in any non-IDLE state → IDLE on the next edge, with the counter cleared. `done` is not pulsed.
  - Abort has priority over every phase transition in the same cycle.
- `beat_cnt` counts from 0 upward within a phase and reads 0 in IDLE and DONE.

## Timing
- Reset (`rst_n`=0 at an edge): state is IDLE. After that edge the outputs are `sel`=11, `ld_ready`=0, `pe_en`=0, `wb_valid`=0, `busy`=0, `done`=0, `beat_cnt`=0.
- Reset mid-job behaves like abort, with no `done` pulse. Reset dominates `start` and `abort`.
- `start` at edge N puts the machine in LOAD, with `ld_ready`=1, in cycle N+1.
- With no stalls, the total job length from `start` to the `done` pulse is 1 + `LOAD_LEN` + `SHIFT_LEN` + `WB_LEN` cycles. `done` is high in cycle N+1+L+S+W.
- The last LOAD beat is accepted in the same cycle that `ld_ready` is last high. `ld_ready` drops in the next cycle, so there is no over-accept.
- Each length of 1 gives a single-cycle phase.
- The counter compares against LEN−1 at the handshake, so it never wraps.

## Structure
- Put the `SEL_LOAD`, `SEL_SHIFT`, `SEL_WB` and `SEL_IDLE` codes and the state encodings as defines in `parameters.vh`. The mux and the sequencer share them.
- Use one sub-module, `phase_counter`, with clear, enable, `CNT_W`-wide count, and a `last` flag that compares against a runtime length input. The FSM instantiates it once and muxes the active LEN into it.

## Test plan
- Reset, then idle: hold `rst_n`=0 for 3 cycles, then release → `sel`=11, `busy`=0, and all enables are 0 for 10 cycles.
- Nominal job, with LOAD=8, SHIFT=16, WB=4, `ld_valid`=1 and `wb_ready`=1 throughout, and `start` at cycle 0:
  - `sel` reads 00 for cycles 1–8, 01 for 9–24, and 10 for 25–28.
  - `done` is high in cycle 29. `busy` falls in cycle 30.
- Load stall: drop `ld_valid` for 5 cycles after beat 3 → `ld_ready` stays high, `beat_cnt` holds at 3, and `done` is delayed by 5 cycles.
- WB backpressure: `wb_ready`=0 for 7 cycles on beat 2 → `wb_valid` and `sel`=10 are held, exactly 4 beats are counted, and `done` is delayed by 7 cycles.
- Abort in SHIFT at `beat_cnt`=5 → IDLE next cycle, `sel`=11, no `done` pulse. A fresh `start` then runs a full nominal job.
- Ignored starts and minimum lengths: pulse `start` during SHIFT → no effect. With all LEN=1, a job takes 4 cycles with `done` in cycle 4. A `start` held high from DONE begins the next job one cycle after IDLE.

Source files
------------

// File: rtl/pe_sequencer_pkg.sv
// pe_sequencer_pkg: shared definitions for the PE-array phase sequencer and
// the column data mux it drives.
//   state_t   : sequencer phase encoding (IDLE, LOAD, SHIFT, WB, DONE)
//   sel_t     : 2-bit mux select code
//   SEL_*     : select codes; SEL_IDLE forces the mux output to zero
//   state_sel : phase -> select code decode, shared by sequencer and mux
package pe_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_LOAD  = 2'b00;
  localparam sel_t SEL_SHIFT = 2'b01;
  localparam sel_t SEL_WB    = 2'b10;
  localparam sel_t SEL_IDLE  = 2'b11;

  function automatic sel_t state_sel(input state_t s);
    sel_t r;
    case (s)
      ST_LOAD:  r = SEL_LOAD;
      ST_SHIFT: r = SEL_SHIFT;
      ST_WB:    r = SEL_WB;
      default:  r = SEL_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pe_sequencer_phase_counter.sv
// phase_counter: per-phase beat/cycle counter with a terminal-count flag.
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset
//   i_clr   : synchronous clear (dominates i_en)
//   i_en    : increment enable
//   i_len   : runtime phase length (1..2**CNT_W-1)
//   o_count : beats completed in the current phase
//   o_last  : o_count == i_len-1, i.e. the current beat completes the phase
module phase_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_len,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Comparing against len-1 lets the phase end on the final beat without
  // the counter ever reaching len, so it cannot wrap.
  assign o_last  = (r_count == i_len - 1'b1);
  assign o_count = r_count;

endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: Moore phase sequencer owning the PE-array mux select.
// A job accepts LOAD_LEN loader beats, runs SHIFT_LEN shift cycles, presents
// WB_LEN write-back beats, then pulses done for one cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : job request, honoured only in IDLE
//   abort      : return to IDLE from any active phase, no done pulse
//   ld_valid   : loader word available      / ld_ready : accepted in LOAD
//   pe_en      : PE shift enable (SHIFT)
//   wb_valid   : write-back word presented (WB) / wb_ready : consumer takes it
//   sel        : mux select (00 load, 01 shift, 10 wb, 11 idle)
//   busy       : not IDLE;  done : completion pulse
//   beat_cnt   : beats/cycles completed in the current phase
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_LEN  = 8,
  parameter int unsigned SHIFT_LEN = 16,
  parameter int unsigned WB_LEN    = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             pe_en,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [CNT_W-1:0] LOAD_LEN_C  = CNT_W'(LOAD_LEN);
  localparam logic [CNT_W-1:0] SHIFT_LEN_C = CNT_W'(SHIFT_LEN);
  localparam logic [CNT_W-1:0] WB_LEN_C    = CNT_W'(WB_LEN);

  state_t           r_state;
  state_t           w_next;
  logic             w_clr;
  logic             w_en;
  logic             w_last;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_count;

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_len   (w_len),
    .o_count (w_count),
    .o_last  (w_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and counter control. The counter is cleared on every phase
  // exit so it reads 0 on entry to the next phase and throughout IDLE/DONE.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    w_len  = LOAD_LEN_C;
    case (r_state)
      ST_IDLE: begin
        w_clr = 1'b1;
        if (start) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_len = LOAD_LEN_C;
        if (ld_valid && ld_ready) begin
          if (w_last) begin
            w_next = ST_SHIFT;
            w_clr  = 1'b1;
          end else begin
            w_en = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        w_len = SHIFT_LEN_C;
        if (w_last) begin
          w_next = ST_WB;
          w_clr  = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_WB: begin
        w_len = WB_LEN_C;
        if (wb_valid && wb_ready) begin
          if (w_last) begin
            w_next = ST_DONE;
            w_clr  = 1'b1;
          end else begin
            w_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_clr  = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_clr  = 1'b1;
        w_next = ST_IDLE;
      end
    endcase
    // Abort overrides whatever phase transition was computed above.
    if (abort && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
      w_clr  = 1'b1;
      w_en   = 1'b0;
    end
  end

  // Output decode from registered state and counter only
  always_comb begin
    sel      = state_sel(r_state);
    ld_ready = (r_state == ST_LOAD);
    pe_en    = (r_state == ST_SHIFT);
    wb_valid = (r_state == ST_WB);
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE);
    beat_cnt = w_count;
  end

endmodule

// File: tb/tb_pe_sequencer.sv
module tb_pe_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, ld_valid, wb_ready;

  logic       a_ld_ready, a_pe_en, a_wb_valid, a_busy, a_done;
  logic [1:0] a_sel;
  logic [7:0] a_beat_cnt;
  logic       b_ld_ready, b_pe_en, b_wb_valid, b_busy, b_done;
  logic [1:0] b_sel;
  logic [7:0] b_beat_cnt;

  pe_sequencer #(
    .LOAD_LEN (8), .SHIFT_LEN (16), .WB_LEN (4), .CNT_W (8)
  ) u_a (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .ld_valid (ld_valid), .ld_ready (a_ld_ready), .pe_en (a_pe_en),
    .wb_valid (a_wb_valid), .wb_ready (wb_ready), .sel (a_sel),
    .busy (a_busy), .done (a_done), .beat_cnt (a_beat_cnt)
  );

  pe_sequencer #(
    .LOAD_LEN (1), .SHIFT_LEN (1), .WB_LEN (1), .CNT_W (8)
  ) u_b (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .ld_valid (ld_valid), .ld_ready (b_ld_ready), .pe_en (b_pe_en),
    .wb_valid (b_wb_valid), .wb_ready (wb_ready), .sel (b_sel),
    .busy (b_busy), .done (b_done), .beat_cnt (b_beat_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a_done_cyc = -1;
  int b_done_cyc = -1;

  // Job model: phase name plus the number of beats still owed in that phase.
  // ph: 0 idle, 1 load, 2 shift, 3 write-back, 4 done
  int m_ph[2]   = '{0, 0};
  int m_left[2] = '{0, 0};
  int m_l[2]    = '{8, 1};
  int m_s[2]    = '{16, 1};
  int m_w[2]    = '{4, 1};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic mstep(input int i);
    if (!rst_n) begin
      m_ph[i] = 0; m_left[i] = 0;
    end else if (m_ph[i] == 0) begin
      if (start) begin m_ph[i] = 1; m_left[i] = m_l[i]; end
    end else if (m_ph[i] == 4) begin
      m_ph[i] = 0;
    end else if (abort) begin
      m_ph[i] = 0; m_left[i] = 0;
    end else if (m_ph[i] == 1) begin
      if (ld_valid) begin
        m_left[i]--;
        if (m_left[i] == 0) begin m_ph[i] = 2; m_left[i] = m_s[i]; end
      end
    end else if (m_ph[i] == 2) begin
      m_left[i]--;
      if (m_left[i] == 0) begin m_ph[i] = 3; m_left[i] = m_w[i]; end
    end else begin
      if (wb_ready) begin
        m_left[i]--;
        if (m_left[i] == 0) m_ph[i] = 4;
      end
    end
  endtask

  // Expected {ld_ready, pe_en, wb_valid, sel, busy, done, beat_cnt}
  function automatic logic [14:0] exp_vec(input int i);
    logic [1:0] s;
    int         len;
    int         beats;
    case (m_ph[i])
      1: begin s = 2'd0; len = m_l[i]; end
      2: begin s = 2'd1; len = m_s[i]; end
      3: begin s = 2'd2; len = m_w[i]; end
      default: begin s = 2'd3; len = 0; end
    endcase
    beats = (m_ph[i] >= 1 && m_ph[i] <= 3) ? len - m_left[i] : 0;
    return {m_ph[i] == 1, m_ph[i] == 2, m_ph[i] == 3, s,
            m_ph[i] != 0, m_ph[i] == 4, 8'(beats)};
  endfunction

  task automatic chk_vec(input string nm, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s outputs actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0);
    mstep(1);
    cyc++;
    @(negedge clk);
    chk_vec("model_a", {a_ld_ready, a_pe_en, a_wb_valid, a_sel, a_busy, a_done, a_beat_cnt}, exp_vec(0));
    chk_vec("model_b", {b_ld_ready, b_pe_en, b_wb_valid, b_sel, b_busy, b_done, b_beat_cnt}, exp_vec(1));
    if (a_done) a_done_cyc = cyc;
    if (b_done) b_done_cyc = cyc;
  endtask

  task automatic wait_done(input int s, input int exp_off, input string nm);
    int got;
    got = -1;
    for (int k = 0; k < 300 && got < 0; k++) begin
      if (a_done) got = cyc - s;
      else tick();
    end
    chk(nm, got, exp_off);
  endtask

  initial begin
    int s;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; wb_ready = 1'b0;

    // Reset for 3 cycles, then 10 idle cycles
    repeat (3) tick();
    chk("rst_sel", int'(a_sel), 3);
    chk("rst_flags", int'({a_ld_ready, a_pe_en, a_wb_valid, a_busy, a_done}), 0);
    chk("rst_beat", int'(a_beat_cnt), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_sel", int'(a_sel), 3);
      chk("idle_flags", int'({a_ld_ready, a_pe_en, a_wb_valid, a_busy, a_done}), 0);
    end

    // Nominal job; the all-ones instance runs its own minimum-length job
    ld_valid = 1'b1; wb_ready = 1'b1;
    s = cyc; b_done_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      chk("nom_sel", int'(a_sel), (k <= 8) ? 0 : (k <= 24) ? 1 : 2);
      tick();
    end
    wait_done(s, 29, "nom_done");
    tick();
    chk("nom_busy_fall", int'(a_busy), 0);
    chk("minlen_done", b_done_cyc - s, 4);

    // Load stall of 5 cycles after beat 3
    tick();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    ld_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_beat", int'(a_beat_cnt), 3);
      chk("stall_ready", int'(a_ld_ready), 1);
      tick();
    end
    ld_valid = 1'b1;
    wait_done(s, 34, "stall_done");
    tick();

    // WB backpressure for 7 cycles while beat 2 is presented
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();
    wb_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("bp_valid", int'(a_wb_valid), 1);
      chk("bp_sel", int'(a_sel), 2);
      chk("bp_beat", int'(a_beat_cnt), 1);
      tick();
    end
    wb_ready = 1'b1;
    wait_done(s, 36, "bp_done");
    tick();

    // Abort in SHIFT at beat_cnt 5, then a fresh full job
    s = cyc;
    a_done_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    chk("abort_pre_beat", int'(a_beat_cnt), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_sel", int'(a_sel), 3);
    chk("abort_busy", int'(a_busy), 0);
    repeat (30) tick();
    chk("abort_no_done", a_done_cyc, -1);
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(s, 29, "post_abort_done");
    tick();

    // Start pulsed during SHIFT is ignored
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(s, 29, "ign_start_done");
    tick();

    // Start held high through DONE: one IDLE cycle, then LOAD
    s = cyc;
    start = 1'b1;
    tick();
    wait_done(s, 29, "held_done");
    tick();
    chk("held_idle_gap", int'(a_busy), 0);
    tick();
    chk("held_reload_sel", int'(a_sel), 0);
    chk("held_reload_rdy", int'(a_ld_ready), 1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 59) == 0);
      ld_valid = ($urandom_range(0, 9) < 7);
      wb_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
